// File: rtl/axiline_pkg.sv
// rtl/axiline_pkg.sv - shared types and helpers for the inner-product sequencer
package axiline_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // Width needed to hold a chunk count in 0..max_chunks inclusive.
    function automatic int chunk_cnt_w(input int max_chunks);
        return $clog2(max_chunks + 1);
    endfunction

endpackage

// File: rtl/ip.sv
// rtl/ip.sv - combinational inner product of one chunk, truncated to bitwidth
module ip #(
    parameter int bitwidth      = 16,
    parameter int inputBitwidth = 8,
    parameter int size          = 8
) (
    input  logic [inputBitwidth*size-1:0] x,
    input  logic [bitwidth*size-1:0]      w,
    output logic [bitwidth-1:0]           y
);

    // Sum of element products; every product and partial sum wraps at bitwidth bits.
    always_comb begin
        logic [bitwidth-1:0] xe;
        logic [bitwidth-1:0] prod;
        y = '0;
        for (int i = 0; i < size; i++) begin
            xe   = {{(bitwidth-inputBitwidth){1'b0}}, x[inputBitwidth*i +: inputBitwidth]};
            prod = xe * w[bitwidth*i +: bitwidth];
            y    = y + prod;
        end
    end

endmodule

// File: rtl/ip_seq.sv
// rtl/ip_seq.sv - sequences num_chunks chunks through ip and returns the accumulated sum
module ip_seq
    import axiline_pkg::*;
#(
    parameter int bitwidth      = 16,
    parameter int inputBitwidth = 8,
    parameter int size          = 8,
    parameter int maxChunks     = 64,
    parameter int CW            = chunk_cnt_w(maxChunks)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CW-1:0]                 num_chunks,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [inputBitwidth*size-1:0] x_chunk,
    input  logic [bitwidth*size-1:0]      w_chunk,
    output logic [CW-1:0]                 chunk_idx,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [bitwidth-1:0]           result
);

    seq_state_e          state_q, state_d;
    logic [bitwidth-1:0] acc_q, acc_d;
    logic [CW-1:0]       idx_q, idx_d;
    logic [CW-1:0]       num_q, num_d;
    logic [bitwidth-1:0] chunk_sum;

    ip #(
        .bitwidth      (bitwidth),
        .inputBitwidth (inputBitwidth),
        .size          (size)
    ) u_ip (
        .x (x_chunk),
        .w (w_chunk),
        .y (chunk_sum)
    );

    // State, accumulator, chunk counter and captured length; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            idx_q   <= '0;
            num_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            num_q   <= num_d;
        end
    end

    // Next-state and handshake outputs; result is driven straight from acc so it holds in DONE.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        num_d     = num_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    num_d   = num_chunks;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = (num_chunks == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (in_valid) begin
                    acc_d = acc_q + chunk_sum;
                    idx_d = idx_q + CW'(1);
                    if (idx_q + CW'(1) == num_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign chunk_idx = idx_q;
    assign result    = acc_q;

endmodule
